// File: rtl/dragon_pkg.sv
// Shared definitions for the multi-dragon game logic: state codes and default widths.
package dragon_pkg;

  localparam int ST_W      = 3;
  localparam int DEF_X_W   = 10;
  localparam int DEF_Y_W   = 9;
  localparam int DEF_MAP_W = 4;

  typedef enum logic [ST_W-1:0] {
    ST_ABSENT = 3'd0,
    ST_CHASE  = 3'd1,
    ST_BITE   = 3'd2,
    ST_EAT    = 3'd3,
    ST_SLAIN  = 3'd4
  } dstate_e;

endpackage

// File: rtl/dragon_fsm.sv
// One dragon: life-cycle state machine, position registers and bite timer.
module dragon_fsm
  import dragon_pkg::*;
#(
  parameter int X_W        = DEF_X_W,
  parameter int Y_W        = DEF_Y_W,
  parameter int MAP_W      = DEF_MAP_W,
  parameter int BITE_RANGE = 4,
  parameter int BITE_TICKS = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic             i_move,
  input  logic [X_W-1:0]   i_player_x,
  input  logic [Y_W-1:0]   i_player_y,
  input  logic [MAP_W-1:0] i_map_x,
  input  logic [MAP_W-1:0] i_map_y,
  input  logic [MAP_W-1:0] i_room_x,
  input  logic [MAP_W-1:0] i_room_y,
  input  logic [X_W-1:0]   i_home_x,
  input  logic [Y_W-1:0]   i_home_y,
  input  logic             i_hit,
  output logic [X_W-1:0]   o_x,
  output logic [Y_W-1:0]   o_y,
  output logic [ST_W-1:0]  o_state,
  output logic             o_eat_nx
);

  localparam int              T_W    = (BITE_TICKS > 1) ? $clog2(BITE_TICKS) : 1;
  localparam logic [T_W-1:0]  T_LAST = T_W'(BITE_TICKS - 1);
  localparam logic [X_W:0]    RX     = (X_W + 1)'(BITE_RANGE);
  localparam logic [Y_W:0]    RY     = (Y_W + 1)'(BITE_RANGE);

  dstate_e        r_state, w_state_nx;
  logic [X_W-1:0] r_x, w_x_nx, w_step_x;
  logic [Y_W-1:0] r_y, w_y_nx, w_step_y;
  logic [T_W-1:0] r_tmr, w_tmr_nx;
  logic           w_room, w_near_step, w_near_now;

  function automatic logic [X_W:0] dist_x(input logic [X_W-1:0] a, input logic [X_W-1:0] b);
    if (a >= b) return {1'b0, a - b};
    else return {1'b0, b - a};
  endfunction

  function automatic logic [Y_W:0] dist_y(input logic [Y_W-1:0] a, input logic [Y_W-1:0] b);
    if (a >= b) return {1'b0, a - b};
    else return {1'b0, b - a};
  endfunction

  assign w_room      = (i_map_x == i_room_x) && (i_map_y == i_room_y);
  assign w_near_now  = (dist_x(r_x, i_player_x) <= RX) && (dist_y(r_y, i_player_y) <= RY);
  assign w_near_step = (dist_x(w_step_x, i_player_x) <= RX) && (dist_y(w_step_y, i_player_y) <= RY);

  // Each axis approaches the player by one pixel, never past it.
  always_comb begin
    w_step_x = r_x;
    w_step_y = r_y;
    if (i_player_x > r_x) w_step_x = r_x + X_W'(1);
    else if (i_player_x < r_x) w_step_x = r_x - X_W'(1);
    else w_step_x = r_x;
    if (i_player_y > r_y) w_step_y = r_y + Y_W'(1);
    else if (i_player_y < r_y) w_step_y = r_y - Y_W'(1);
    else w_step_y = r_y;
  end

  always_comb begin
    w_state_nx = r_state;
    w_x_nx     = r_x;
    w_y_nx     = r_y;
    w_tmr_nx   = r_tmr;
    case (r_state)
      ST_ABSENT: begin
        w_x_nx = i_home_x;
        w_y_nx = i_home_y;
        if (w_room) w_state_nx = ST_CHASE;
        else w_state_nx = ST_ABSENT;
      end
      ST_CHASE: begin
        if (i_hit) begin
          w_state_nx = ST_SLAIN;
        end else if (!w_room) begin
          w_state_nx = ST_ABSENT;
          w_x_nx     = i_home_x;
          w_y_nx     = i_home_y;
        end else if (i_move) begin
          w_x_nx = w_step_x;
          w_y_nx = w_step_y;
          if (w_near_step) begin
            w_state_nx = ST_BITE;
            w_tmr_nx   = '0;
          end else begin
            w_state_nx = ST_CHASE;
          end
        end else begin
          w_state_nx = ST_CHASE;
        end
      end
      ST_BITE: begin
        if (i_hit) begin
          w_state_nx = ST_SLAIN;
        end else if (!w_room) begin
          w_state_nx = ST_ABSENT;
          w_x_nx     = i_home_x;
          w_y_nx     = i_home_y;
        end else if (i_tick) begin
          if (!w_near_now) w_state_nx = ST_CHASE;
          else if (r_tmr == T_LAST) w_state_nx = ST_EAT;
          else w_tmr_nx = r_tmr + T_W'(1);
        end else begin
          w_state_nx = ST_BITE;
        end
      end
      ST_EAT: begin
        w_x_nx = i_player_x;
        w_y_nx = i_player_y;
      end
      ST_SLAIN: w_state_nx = ST_SLAIN;
      default: begin
        w_state_nx = ST_ABSENT;
        w_x_nx     = i_home_x;
        w_y_nx     = i_home_y;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_ABSENT;
      r_x     <= '0;
      r_y     <= '0;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_x     <= w_x_nx;
      r_y     <= w_y_nx;
      r_tmr   <= w_tmr_nx;
    end
  end

  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_state  = r_state;
  assign o_eat_nx = (w_state_nx == ST_EAT);

endmodule

// File: rtl/dragon_controller.sv
// Multi-dragon controller: shared move divider, per-dragon FSMs, sticky eaten flag and slain count.
module dragon_controller
  import dragon_pkg::*;
#(
  parameter int NUM_DRAGONS = 3,
  parameter int X_W         = DEF_X_W,
  parameter int Y_W         = DEF_Y_W,
  parameter int MAP_W       = DEF_MAP_W,
  parameter int STEP_DIV    = 2,
  parameter int BITE_RANGE  = 4,
  parameter int BITE_TICKS  = 16
) (
  input  logic                               clk_vga,
  input  logic                               reset_n,
  input  logic                               tick,
  input  logic [X_W-1:0]                     player_x,
  input  logic [Y_W-1:0]                     player_y,
  input  logic [MAP_W-1:0]                   map_x,
  input  logic [MAP_W-1:0]                   map_y,
  input  logic [NUM_DRAGONS*MAP_W-1:0]       dragon_map_x,
  input  logic [NUM_DRAGONS*MAP_W-1:0]       dragon_map_y,
  input  logic [NUM_DRAGONS*X_W-1:0]         home_x,
  input  logic [NUM_DRAGONS*Y_W-1:0]         home_y,
  input  logic [NUM_DRAGONS-1:0]             sword_hit,
  output logic [NUM_DRAGONS*X_W-1:0]         dragon_x,
  output logic [NUM_DRAGONS*Y_W-1:0]         dragon_y,
  output logic [NUM_DRAGONS*ST_W-1:0]        dragon_state,
  output logic                               player_eaten,
  output logic [$clog2(NUM_DRAGONS+1)-1:0]   slain_count
);

  localparam int             D_W      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [D_W-1:0] DIV_LAST = D_W'(STEP_DIV - 1);
  localparam int             C_W      = $clog2(NUM_DRAGONS + 1);

  logic [D_W-1:0]         r_div;
  logic                   w_move;
  logic [NUM_DRAGONS-1:0] w_eat_nx, w_slain;
  logic                   r_eaten;
  logic [C_W-1:0]         r_slain, w_slain_cnt;

  assign w_move = tick && (r_div == DIV_LAST);

  // Tick divider shared by all dragons; wraps on the move tick.
  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) r_div <= '0;
    else if (w_move) r_div <= '0;
    else if (tick) r_div <= r_div + D_W'(1);
    else r_div <= r_div;
  end

  for (genvar g = 0; g < NUM_DRAGONS; g++) begin : g_dragon
    dragon_fsm #(
      .X_W(X_W), .Y_W(Y_W), .MAP_W(MAP_W),
      .BITE_RANGE(BITE_RANGE), .BITE_TICKS(BITE_TICKS)
    ) u_fsm (
      .i_clk      (clk_vga),
      .i_rst_n    (reset_n),
      .i_tick     (tick),
      .i_move     (w_move),
      .i_player_x (player_x),
      .i_player_y (player_y),
      .i_map_x    (map_x),
      .i_map_y    (map_y),
      .i_room_x   (dragon_map_x[g*MAP_W +: MAP_W]),
      .i_room_y   (dragon_map_y[g*MAP_W +: MAP_W]),
      .i_home_x   (home_x[g*X_W +: X_W]),
      .i_home_y   (home_y[g*Y_W +: Y_W]),
      .i_hit      (sword_hit[g]),
      .o_x        (dragon_x[g*X_W +: X_W]),
      .o_y        (dragon_y[g*Y_W +: Y_W]),
      .o_state    (dragon_state[g*ST_W +: ST_W]),
      .o_eat_nx   (w_eat_nx[g])
    );
    assign w_slain[g] = (dragon_state[g*ST_W +: ST_W] == ST_SLAIN);
  end

  always_comb begin
    w_slain_cnt = '0;
    for (int i = 0; i < NUM_DRAGONS; i++) w_slain_cnt = w_slain_cnt + C_W'(w_slain[i]);
  end

  // Eaten is taken from the next-state so it rises together with the EAT code.
  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      r_eaten <= 1'b0;
      r_slain <= '0;
    end else begin
      r_eaten <= r_eaten | (|w_eat_nx);
      r_slain <= w_slain_cnt;
    end
  end

  assign player_eaten = r_eaten;
  assign slain_count  = r_slain;

endmodule
